// File: rtl/window_generator_if.sv
// Pixel-stream in / sliding-window out bundle for the window generator.
// The slave modport is the generator side; the master modport is the side
// that produces pixels and consumes windows.
interface window_generator_if #(
  parameter int KERNEL_SIZE = 3,
  parameter int WORD_SIZE   = 16,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  logic signed [WORD_SIZE-1:0]                               pixel_in;
  logic                                                      pixel_valid;
  logic                                                      start_of_frame;
  logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] window_out;
  logic                                                      window_valid;
  logic        [XW-1:0]                                      win_x;
  logic        [YW-1:0]                                      win_y;
  logic                                                      frame_done;

  modport master (
    output pixel_in, pixel_valid, start_of_frame,
    input  window_out, window_valid, win_x, win_y, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid, start_of_frame,
    output window_out, window_valid, win_x, win_y, frame_done
  );

endinterface

// File: rtl/window_generator.sv
// Raster pixel stream to KxK sliding window. K-1 full-width line buffers hold
// the previous rows; a KxK register array holds the window, shifting one
// column left per accepted pixel. Only windows lying fully inside the image
// are flagged valid; no padding is produced.
module window_generator #(
  parameter int KERNEL_SIZE = 3,
  parameter int WORD_SIZE   = 16,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input logic              clk,
  input logic              reset,
  window_generator_if.slave bus
);

  localparam int K  = KERNEL_SIZE;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [XW-1:0] X_LAST      = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_FIRST_WIN = XW'(K - 1);
  localparam logic [YW-1:0] Y_FIRST_WIN = YW'(K - 1);

  typedef logic [WORD_SIZE-1:0]                   word_t;
  typedef logic [K-1:0][K-1:0][WORD_SIZE-1:0]     window_t;

  // Raster position of the next expected pixel.
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Position of the pixel being accepted this cycle (start_of_frame forces 0,0).
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          accept;

  // Registered outputs.
  window_t       window_q,       window_d;
  logic          window_valid_q, window_valid_d;
  logic [XW-1:0] win_x_q,        win_x_d;
  logic [YW-1:0] win_y_q,        win_y_d;
  logic          frame_done_q,   frame_done_d;

  // Line buffer r holds row y-K+1+r; the incoming column stacks the K-1
  // buffered rows on top of the live pixel.
  word_t line_buf [K-1][IMG_WIDTH];
  word_t col_in   [K];

  // Current pixel position and acceptance qualifier.
  always_comb begin
    accept = bus.pixel_valid;
    cur_x  = bus.start_of_frame ? '0 : x_q;
    cur_y  = bus.start_of_frame ? '0 : y_q;
  end

  // Incoming window column: buffered rows at the current column, then pixel_in.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_in[r] = line_buf[r][cur_x];
    end
    col_in[K-1] = bus.pixel_in;
  end

  // Next-state for counters, window shift and output flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    x_d            = x_q;
    y_d            = y_q;
    window_d       = window_q;
    win_x_d        = win_x_q;
    win_y_d        = win_y_q;
    window_valid_d = 1'b0;
    frame_done_d   = 1'b0;

    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          window_d[r][c] = window_q[r][c+1];
        end
        window_d[r][K-1] = col_in[r];
      end

      win_x_d        = cur_x;
      win_y_d        = cur_y;
      window_valid_d = (cur_x >= X_FIRST_WIN) && (cur_y >= Y_FIRST_WIN);
      frame_done_d   = (cur_x == X_LAST) && (cur_y == Y_LAST);

      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
        y_d = cur_y;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      window_q       <= '0;
      window_valid_q <= 1'b0;
      win_x_q        <= '0;
      win_y_q        <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      window_q       <= window_d;
      window_valid_q <= window_valid_d;
      win_x_q        <= win_x_d;
      win_y_q        <= win_y_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Line buffer advance: buffer r takes buffer r+1's word, the last takes pixel_in.
  always_ff @(posedge clk) begin
    // NOTE: the line buffers are deliberately not reset; stale rows are never
    // exposed because a window only becomes valid once K fresh rows exist.
    if (accept) begin
      for (int r = 0; r < K - 1; r++) begin
        line_buf[r][cur_x] <= col_in[r+1];
      end
    end
  end

  assign bus.window_out   = window_q;
  assign bus.window_valid = window_valid_q;
  assign bus.win_x        = win_x_q;
  assign bus.win_y        = win_y_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench for window_generator (K=3, 5x4 image, 8-bit pixels).
// A reference model keeps the current frame as a 2-D image and derives each
// expected window directly from image coordinates.
module tb_window_generator;

  localparam int K  = 3;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WS = 8;

  typedef logic [K-1:0][K-1:0][WS-1:0] win_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  window_generator_if #(
    .KERNEL_SIZE(K), .WORD_SIZE(WS), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) bus ();

  window_generator #(
    .KERNEL_SIZE(K), .WORD_SIZE(WS), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [WS-1:0] img [H][W];
  int            mx, my;
  int            win_count;
  logic          prev_valid;
  bit            chk_b2b;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    win_t gw;
    gw = bus.window_out;
    check({tag, "_window_out"},   gw,               '0);
    check({tag, "_window_valid"}, bus.window_valid, 0);
    check({tag, "_win_x"},        bus.win_x,        0);
    check({tag, "_win_y"},        bus.win_y,        0);
    check({tag, "_frame_done"},   bus.frame_done,   0);
  endtask

  // One clock: drive inputs, advance the model, check registered outputs.
  task automatic step(input logic v, input logic sof, input logic [WS-1:0] pix);
    logic ev, ed;
    int   ex, ey;
    win_t ew, gw;
    bus.pixel_valid    = v;
    bus.start_of_frame = sof;
    bus.pixel_in       = pix;
    ev = 1'b0; ed = 1'b0; ex = 0; ey = 0; ew = '0;
    if (v) begin
      if (sof) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = pix;
      ev = (mx >= K - 1) && (my >= K - 1);
      ed = (mx == W - 1) && (my == H - 1);
      ex = mx;
      ey = my;
      if (ev) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            ew[r][c] = img[my-K+1+r][mx-K+1+c];
      end
      mx++;
      if (mx == W) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end
    end
    @(posedge clk);
    #1;
    check("window_valid", bus.window_valid, ev);
    check("frame_done",   bus.frame_done,   ed);
    if (ev) begin
      gw = bus.window_out;
      check("window_out", gw,        ew);
      check("win_x",      bus.win_x, ex);
      check("win_y",      bus.win_y, ey);
      win_count++;
    end
    if (chk_b2b) check("no_back_to_back", prev_valid && bus.window_valid, 0);
    prev_valid = bus.window_valid;
  endtask

  // One frame of pixels offset+i; gap_mode 0 = continuous, 1 = every other
  // cycle, 2 = random idle gaps.
  task automatic run_frame(input bit first_sof, input int gap_mode, input int offset);
    for (int i = 0; i < W * H; i++) begin
      if (gap_mode == 1) step(1'b0, 1'b0, WS'($urandom));
      if (gap_mode == 2) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) step(1'b0, 1'b1, WS'($urandom));
      end
      step(1'b1, first_sof && (i == 0), WS'(offset + i));
    end
  endtask

  task automatic partial(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, WS'(100 + i));
  endtask

  initial begin
    win_t exp_hold, gw;
    bus.pixel_valid    = 1'b0;
    bus.start_of_frame = 1'b0;
    bus.pixel_in       = '0;
    mx = 0; my = 0; win_count = 0; prev_valid = 1'b0; chk_b2b = 1'b0;

    // Reset state.
    reset = 1'b1;
    #12;
    check_outputs_zero("reset");
    reset = 1'b0;

    // Continuous frame: six windows, last window held through an idle cycle.
    win_count = 0;
    run_frame(1'b1, 0, 0);
    check("s1_window_count", win_count, 6);
    step(1'b0, 1'b0, 8'h55);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        exp_hold[r][c] = WS'((1 + r) * W + 2 + c);
    gw = bus.window_out;
    check("s1_hold_last_window", gw, exp_hold);

    // Every-other-cycle frame, back-to-back via counter wrap, no start_of_frame.
    win_count = 0;
    chk_b2b   = 1'b1;
    run_frame(1'b0, 1, 0);
    chk_b2b   = 1'b0;
    check("s2_window_count", win_count, 6);

    // Continuous back-to-back frame after the wrap.
    win_count = 0;
    run_frame(1'b0, 0, 0);
    check("s4_window_count", win_count, 6);

    // Abort mid-frame with start_of_frame on the 8th pixel.
    win_count = 0;
    partial(7);
    run_frame(1'b1, 0, 0);
    check("s5_window_count", win_count, 6);

    // Asynchronous reset between edges mid-frame.
    partial(9);
    reset = 1'b1;
    #2;
    check_outputs_zero("midreset");
    reset = 1'b0;
    mx = 0; my = 0; prev_valid = 1'b0;
    win_count = 0;
    run_frame(1'b0, 0, 0);
    check("s6_window_count", win_count, 6);

    // Negative pixel values.
    win_count = 0;
    run_frame(1'b1, 2, -128);
    check("s7_window_count", win_count, 6);

    // Random traffic: random values, gaps and occasional start_of_frame.
    for (int i = 0; i < 800; i++) begin
      logic v, sof;
      v   = ($urandom_range(0, 3) != 0);
      sof = ($urandom_range(0, 60) == 0);
      step(v, sof, WS'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
